rc_poly_resampler: RTL



---
 rtl/rc_poly_resampler_pkg.sv | 28 ++
 rtl/rc_poly_resampler_if.sv | 35 +++
 rtl/rc_poly_resampler_coef_file.sv | 28 ++
 rtl/rc_poly_resampler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/rc_poly_resampler_pkg.sv
// Shared types and helpers for the rational polyphase resampler.
package rc_pkg;

  typedef enum logic [1:0] {NEED, MAC, OUT} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/rc_poly_resampler_if.sv
// Sample, result and coefficient-load signals of the resampler.
interface rc_poly_resampler_if #(
  parameter int DW = 8,
  parameter int CW = 9,
  parameter int OW = 9,
  parameter int L  = 3,
  parameter int NT = 4
) ();
  import rc_pkg::*;

  localparam int PW  = idx_w(L);
  localparam int CAW = idx_w(L * NT);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  x_in;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [OW-1:0]  y_out;
  logic                  coef_we;
  logic [CAW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic [PW-1:0]         phase_o;

  modport master (
    output in_valid, x_in, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, y_out, phase_o
  );

  modport slave (
    input  in_valid, x_in, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, y_out, phase_o
  );

endinterface

// File: rtl/rc_poly_resampler_coef_file.sv
// Coefficient register file: synchronous write, asynchronous read, cleared on reset.
module rc_coef_file #(
  parameter int CW    = 9,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [CW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [CW-1:0] rdata
);

  logic signed [CW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/rc_poly_resampler.sv
// Rational L/M resampler: polyphase FIR evaluated by one sequential MAC.
//   state | meaning
//   NEED  | pull inputs while acc >= L, then latch phase = acc
//   MAC   | NT cycles accumulating coef[ph*NT+k] * d[k]
//   OUT   | hold y_out/phase_o until out_ready, then acc += M
module rc_poly_resampler #(
  parameter int DW    = 8,
  parameter int CW    = 9,
  parameter int OW    = 9,
  parameter int L     = 3,
  parameter int M     = 4,
  parameter int NT    = 4,
  parameter int SHIFT = 8
) (
  input logic             clk,
  input logic             reset,
  rc_poly_resampler_if.slave bus
);
  import rc_pkg::*;

  localparam int AW  = clog2(L + M) + 1;
  localparam int PW  = idx_w(L);
  localparam int KW  = idx_w(NT);
  localparam int CAW = idx_w(L * NT);
  localparam int SW  = DW + CW + clog2(NT);

  state_t               state, state_nxt;
  logic [AW-1:0]        acc;
  logic signed [DW-1:0] d [NT];
  logic signed [SW-1:0] sum, prod, sum_nxt;
  logic [PW-1:0]        ph;
  logic [KW-1:0]        k;
  logic signed [CW-1:0] coef_rd;
  logic [CAW-1:0]       coef_raddr;
  logic signed [OW-1:0] y_q;
  logic                 in_ready_c, need_go, mac_last, in_hs, out_hs;

  rc_coef_file #(.CW(CW), .DEPTH(L * NT), .AW(CAW)) u_coef (
    .clk   (clk),
    .reset (reset),
    .we    (bus.coef_we),
    .waddr (bus.coef_addr),
    .wdata (bus.coef_data),
    .raddr (coef_raddr),
    .rdata (coef_rd)
  );

  assign coef_raddr = CAW'(int'(ph) * NT + int'(k));
  assign prod       = SW'(coef_rd) * SW'(d[k]);
  assign sum_nxt    = sum + prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NEED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    need_go    = 1'b0;
    mac_last   = 1'b0;
    case (state)
      NEED: begin
        if (acc >= AW'(L)) begin
          in_ready_c = 1'b1;
        end else begin
          need_go   = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        if (k == KW'(NT - 1)) begin
          mac_last  = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_nxt = NEED;
      end
      default: state_nxt = NEED;
    endcase
  end

  assign in_hs = bus.in_valid & in_ready_c;
  assign out_hs = (state == OUT) & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= AW'(L);
      for (int i = 0; i < NT; i++) d[i] <= '0;
      sum <= '0;
      k   <= '0;
      ph  <= '0;
      y_q <= '0;
    end else begin
      if (in_hs) begin
        d[0] <= bus.x_in;
        for (int i = 1; i < NT; i++) d[i] <= d[i-1];
        acc <= acc - AW'(L);
      end
      if (out_hs) acc <= acc + AW'(M);
      if (need_go) begin
        ph  <= PW'(acc);
        k   <= '0;
        sum <= '0;
      end
      if (state == MAC) begin
        if (mac_last) begin
          // Arithmetic shift floors toward -inf before clamping.
          y_q <= OW'(sat(64'(sum_nxt) >>> SHIFT, OW));
          sum <= '0;
          k   <= '0;
        end else begin
          sum <= sum_nxt;
          k   <= k + KW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == OUT);
  assign bus.y_out     = y_q;
  assign bus.phase_o   = ph;

endmodule
